// File: rtl/expr_stream_eval.sv
// Streaming ASCII expression recognizer/evaluator: NUMBER (OP NUMBER)* with multi-digit operands.
// Define EXPR_MUL_EN to accept '*' with precedence over '+'/'-'.
module expr_stream_eval #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             in_ready,
  output logic             out,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       ndigits
);

  typedef enum logic [1:0] {S_START, S_NUM, S_OP, S_ERR} state_t;

  localparam logic [3:0] MAX_ND = 4'(MAX_DIGITS);

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] num;
  logic signed [WIDTH-1:0] num_next;
  logic signed [WIDTH-1:0] prod_cur;
  logic signed [WIDTH-1:0] prod_next;
  logic signed [WIDTH-1:0] res_q;
  logic                    neg;
  logic [3:0]              ndig;

  logic       is_digit, is_addsub, is_mul;
  logic [3:0] digit_val;

  function automatic logic signed [WIDTH-1:0] wrap_mac10(
    input logic signed [WIDTH-1:0] a,
    input logic [3:0]              d
  );
    logic signed [WIDTH-1:0] ten;
    ten = $signed(WIDTH'(10));
    return a * ten + $signed(WIDTH'(d));
  endfunction

  function automatic logic signed [WIDTH-1:0] wrap_signed_add(
    input logic signed [WIDTH-1:0] a,
    input logic                    sub,
    input logic signed [WIDTH-1:0] b
  );
    return sub ? (a - b) : (a + b);
  endfunction

  assign is_digit  = (in >= 8'h30) && (in <= 8'h39);
  assign is_addsub = (in == 8'h2B) || (in == 8'h2D);
  assign is_mul    = (in == 8'h2A);
  assign digit_val = 4'(in - 8'h30);
  assign num_next  = wrap_mac10(num, digit_val);

`ifdef EXPR_MUL_EN
  localparam bit MUL_EN = 1'b1;
  logic signed [WIDTH-1:0] term;

  assign prod_cur  = term * num;
  assign prod_next = term * num_next;

  // term holds the product of the '*' chain preceding the operand in progress
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      term <= $signed(WIDTH'(1));
    end else if (in_valid && state_nxt != S_ERR) begin
      if (is_mul)
        term <= prod_cur;
      else if (is_addsub)
        term <= $signed(WIDTH'(1));
    end
  end
`else
  localparam bit MUL_EN = 1'b0;

  assign prod_cur  = num;
  assign prod_next = num_next;
`endif

  always_ff @(posedge clk) begin
    if (!clr_n)
      state <= S_START;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      unique case (state)
        S_START, S_OP: state_nxt = is_digit ? S_NUM : S_ERR;
        S_NUM: begin
          if (is_digit)
            state_nxt = (ndig == MAX_ND) ? S_ERR : S_NUM;
          else if (is_addsub || (is_mul && MUL_EN))
            state_nxt = S_OP;
          else
            state_nxt = S_ERR;
        end
        S_ERR: state_nxt = S_ERR;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b1;
    out      = (state == S_NUM);
    err      = (state == S_ERR);
    result   = res_q;
    ndigits  = ndig;
  end

  // Datapath freezes on any transition into S_ERR so result keeps its last legal value
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      acc   <= '0;
      num   <= '0;
      neg   <= 1'b0;
      res_q <= '0;
      ndig  <= '0;
    end else if (in_valid && state_nxt != S_ERR) begin
      if (is_digit) begin
        num   <= num_next;
        ndig  <= ndig + 4'd1;
        res_q <= wrap_signed_add(acc, neg, prod_next);
      end else begin
        num  <= '0;
        ndig <= '0;
        if (is_addsub) begin
          acc <= wrap_signed_add(acc, neg, prod_cur);
          neg <= (in == 8'h2D);
        end
      end
    end
  end

endmodule

// File: tb/tb_expr_stream_eval.sv
// Table-driven bench for expr_stream_eval; per-character vectors plus hand-written hold/reset sequences.
module tb_expr_stream_eval;

  localparam int WIDTH      = 8;
  localparam int MAX_DIGITS = 3;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             in_valid;
  logic [7:0]       in;
  logic             in_ready;
  logic             out;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [3:0]       ndigits;

  expr_stream_eval #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .in_valid (in_valid),
    .in       (in),
    .in_ready (in_ready),
    .out      (out),
    .err      (err),
    .result   (result),
    .ndigits  (ndigits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr_n;
    logic       vld;
    logic [7:0] ch;
    logic       o;
    logic       e;
    logic [7:0] r;
    logic [3:0] nd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic row(input logic c, input logic v, input logic [7:0] ch,
                     input logic o, input logic e, input logic [7:0] r, input logic [3:0] nd);
    vec_t x;
    x.clr_n = c; x.vld = v; x.ch = ch; x.o = o; x.e = e; x.r = r; x.nd = nd;
    vecs.push_back(x);
  endtask

  task automatic ch_row(input logic [7:0] ch, input logic o, input logic e,
                        input logic [7:0] r, input logic [3:0] nd);
    row(1'b1, 1'b1, ch, o, e, r, nd);
  endtask

  task automatic rst_row();
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 4'd0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic o, input logic e,
                            input logic [7:0] r, input logic [3:0] nd);
    check({tag, ".out"},      32'(out),      32'(o));
    check({tag, ".err"},      32'(err),      32'(e));
    check({tag, ".result"},   32'(result),   32'(r));
    check({tag, ".ndigits"},  32'(ndigits),  32'(nd));
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic step(input logic c, input logic v, input logic [7:0] ch);
    @(negedge clk);
    clr_n    = c;
    in_valid = v;
    in       = ch;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n    = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;

    rst_row();
    // "1+9+8" -> 18
    ch_row("1", 1, 0, 8'd1, 4'd1);
    ch_row("+", 0, 0, 8'd1, 4'd0);
    ch_row("9", 1, 0, 8'd10, 4'd1);
    ch_row("+", 0, 0, 8'd10, 4'd0);
    ch_row("8", 1, 0, 8'd18, 4'd1);
    rst_row();
    // "12-30" -> 238
    ch_row("1", 1, 0, 8'd1, 4'd1);
    ch_row("2", 1, 0, 8'd12, 4'd2);
    ch_row("-", 0, 0, 8'd12, 4'd0);
    ch_row("3", 1, 0, 8'd9, 4'd1);
    ch_row("0", 1, 0, 8'd238, 4'd2);
    rst_row();
    // "1++" then digits stay in error
    ch_row("1", 1, 0, 8'd1, 4'd1);
    ch_row("+", 0, 0, 8'd1, 4'd0);
    ch_row("+", 0, 1, 8'd1, 4'd0);
    ch_row("5", 0, 1, 8'd1, 4'd0);
    ch_row("6", 0, 1, 8'd1, 4'd0);
    rst_row();
    // "1234" overflows MAX_DIGITS
    ch_row("1", 1, 0, 8'd1, 4'd1);
    ch_row("2", 1, 0, 8'd12, 4'd2);
    ch_row("3", 1, 0, 8'd123, 4'd3);
    ch_row("4", 0, 1, 8'd123, 4'd3);
    rst_row();
    // "007+1" -> 8
    ch_row("0", 1, 0, 8'd0, 4'd1);
    ch_row("0", 1, 0, 8'd0, 4'd2);
    ch_row("7", 1, 0, 8'd7, 4'd3);
    ch_row("+", 0, 0, 8'd7, 4'd0);
    ch_row("1", 1, 0, 8'd8, 4'd1);
    rst_row();
    // "2+3*4"
    ch_row("2", 1, 0, 8'd2, 4'd1);
    ch_row("+", 0, 0, 8'd2, 4'd0);
    ch_row("3", 1, 0, 8'd5, 4'd1);
`ifdef EXPR_MUL_EN
    ch_row("*", 0, 0, 8'd5, 4'd0);
    ch_row("4", 1, 0, 8'd14, 4'd1);
`else
    ch_row("*", 0, 1, 8'd5, 4'd1);
    ch_row("4", 0, 1, 8'd5, 4'd1);
`endif
    rst_row();
    // wrap-around: 999 mod 256 = 231, then 255+1 = 0
    ch_row("9", 1, 0, 8'd9, 4'd1);
    ch_row("9", 1, 0, 8'd99, 4'd2);
    ch_row("9", 1, 0, 8'd231, 4'd3);
    rst_row();
    ch_row("2", 1, 0, 8'd2, 4'd1);
    ch_row("5", 1, 0, 8'd25, 4'd2);
    row(1'b1, 1'b0, "7", 1, 0, 8'd25, 4'd2);
    ch_row("5", 1, 0, 8'd255, 4'd3);
    ch_row("+", 0, 0, 8'd255, 4'd0);
    ch_row("1", 1, 0, 8'd0, 4'd1);
    rst_row();
    // illegal first character, and letter after operator
    ch_row("a", 0, 1, 8'd0, 4'd0);
    rst_row();
    ch_row("4", 1, 0, 8'd4, 4'd1);
    ch_row("-", 0, 0, 8'd4, 4'd0);
    ch_row("x", 0, 1, 8'd4, 4'd0);
    rst_row();

    foreach (vecs[i]) begin
      step(vecs[i].clr_n, vecs[i].vld, vecs[i].ch);
      check_outs($sformatf("vec%0d", i), vecs[i].o, vecs[i].e, vecs[i].r, vecs[i].nd);
    end

    // "1+" then idle, then reset colliding with a valid digit
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, "1");
    step(1'b1, 1'b1, "+");
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, "7");
      check_outs($sformatf("hold%0d", k), 1'b0, 1'b0, 8'd1, 4'd0);
    end
    step(1'b0, 1'b1, "5");
    check_outs("rst_wins", 1'b0, 1'b0, 8'd0, 4'd0);
    step(1'b1, 1'b0, "5");
    check_outs("post_rst", 1'b0, 1'b0, 8'd0, 4'd0);
    step(1'b1, 1'b1, "5");
    check_outs("start_digit", 1'b1, 1'b0, 8'd5, 4'd1);

    // reset aborts an error state too
    step(1'b1, 1'b1, "?");
    check_outs("err_again", 1'b0, 1'b1, 8'd5, 4'd1);
    step(1'b0, 1'b1, "9");
    check_outs("err_clear", 1'b0, 1'b0, 8'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
